// File: rtl/dma_ci_if.sv
// Bundle of the CI, buffer port B and system bus signals seen by the DMA controller.
// master = controller side, slave = CPU/SSRAM/bus environment side.
interface dma_ci_if;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;
    logic [8:0]  bufAddress;
    logic        bufWriteEnable;
    logic [31:0] bufDataOut;
    logic [31:0] bufDataIn;
    logic        busRequest;
    logic        busGrant;
    logic [31:0] busAddress;
    logic [7:0]  busBurstSize;
    logic        busStart;
    logic        busRead;
    logic [31:0] busDataIn;
    logic        busDataInValid;
    logic [31:0] busDataOut;
    logic        busDataOutValid;
    logic        busBusy;
    logic        busEndTransaction;
    logic        busError;

    modport master (
        input  start, ciN, valueA, valueB, bufDataIn, busGrant, busDataIn,
               busDataInValid, busBusy, busEndTransaction, busError,
        output done, result, bufAddress, bufWriteEnable, bufDataOut, busRequest,
               busAddress, busBurstSize, busStart, busRead, busDataOut, busDataOutValid
    );

    modport slave (
        output start, ciN, valueA, valueB, bufDataIn, busGrant, busDataIn,
               busDataInValid, busBusy, busEndTransaction, busError,
        input  done, result, bufAddress, bufWriteEnable, bufDataOut, busRequest,
               busAddress, busBurstSize, busStart, busRead, busDataOut, busDataOutValid
    );
endinterface

// File: rtl/dma_ci_controller.sv
// Custom-instruction-configured DMA moving word blocks between the system bus and port B of the CI buffer.
// state    | meaning
// IDLE     | waiting for a CI start
// REQ      | requesting the bus; issues busStart on grant
// RD_DATA  | copying read beats into the buffer
// WR_FETCH | addressing the buffer for the next write beat
// WR_DATA  | presenting a write beat until the slave accepts it
module dma_ci_controller #(
    parameter logic [7:0] customId = 8'h00
) (
    input  logic     clock,
    input  logic     reset,
    dma_ci_if.master ci
);
    typedef enum logic [2:0] {IDLE, REQ, RD_DATA, WR_FETCH, WR_DATA} state_t;

    state_t      state_q, state_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [8:0]  buf_addr_q, buf_addr_d;
    logic [9:0]  block_size_q, block_size_d;
    logic [7:0]  burst_size_q, burst_size_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;
    logic        dir_rd_q, dir_rd_d;
    logic [31:0] cur_bus_q, cur_bus_d;
    logic [8:0]  cur_buf_q, cur_buf_d;
    logic [9:0]  remaining_q, remaining_d;
    logic [8:0]  beats_q, beats_d;
    logic        bus_request_q, bus_request_d;
    logic        bus_start_q, bus_start_d;
    logic [31:0] bus_address_q, bus_address_d;
    logic [7:0]  bus_burst_size_q, bus_burst_size_d;
    logic        bus_read_q, bus_read_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wdata_hold_q, wdata_hold_d;

    logic        ci_active, ci_write, rd_beat;
    logic [2:0]  sel;
    logic [9:0]  burst_plus, burst_beats;
    logic [31:0] rd_data;
    logic        unused_ok;

    assign ci_active   = ci.start && (ci.ciN == customId);
    assign ci_write    = ci_active && ci.valueA[9];
    assign sel         = ci.valueA[12:10];
    assign burst_plus  = {2'b00, burst_size_q} + 10'd1;
    assign burst_beats = (burst_plus < remaining_q) ? burst_plus : remaining_q;
    assign rd_beat     = (state_q == RD_DATA) && ci.busDataInValid && (remaining_q != 10'd0);
    assign unused_ok   = ^{ci.valueA[31:13], ci.valueA[8:0]};

    always_comb begin
        rd_data = 32'd0;
        if (ci_active && !ci.valueA[9]) begin
            case (sel)
                3'd1:    rd_data = bus_addr_q;
                3'd2:    rd_data = {23'd0, buf_addr_q};
                3'd3:    rd_data = {22'd0, block_size_q};
                3'd4:    rd_data = {24'd0, burst_size_q};
                3'd5:    rd_data = {30'd0, error_q, busy_q};
                default: rd_data = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d          = state_q;
        bus_addr_d       = bus_addr_q;
        buf_addr_d       = buf_addr_q;
        block_size_d     = block_size_q;
        burst_size_d     = burst_size_q;
        busy_d           = busy_q;
        error_d          = error_q;
        dir_rd_d         = dir_rd_q;
        cur_bus_d        = cur_bus_q;
        cur_buf_d        = cur_buf_q;
        remaining_d      = remaining_q;
        beats_d          = beats_q;
        bus_request_d    = bus_request_q;
        bus_start_d      = 1'b0;
        bus_address_d    = 32'd0;
        bus_burst_size_d = 8'd0;
        bus_read_d       = 1'b0;
        wdata_d          = wdata_q;
        wdata_hold_d     = wdata_hold_q;

        if (ci_write && !busy_q) begin
            case (sel)
                3'd1: bus_addr_d   = {ci.valueB[31:2], 2'b00};
                3'd2: buf_addr_d   = ci.valueB[8:0];
                3'd3: block_size_d = (ci.valueB > 32'd512) ? 10'd512 : ci.valueB[9:0];
                3'd4: burst_size_d = ci.valueB[7:0];
                3'd5: begin
                    if (ci.valueB[1:0] == 2'b01 || ci.valueB[1:0] == 2'b10) begin
                        error_d  = 1'b0;
                        dir_rd_d = (ci.valueB[1:0] == 2'b01);
                        if (block_size_q != 10'd0) begin
                            cur_bus_d     = bus_addr_q;
                            cur_buf_d     = buf_addr_q;
                            remaining_d   = block_size_q;
                            busy_d        = 1'b1;
                            bus_request_d = 1'b1;
                            state_d       = REQ;
                        end
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            REQ: begin
                bus_request_d = 1'b1;
                if (ci.busGrant && bus_request_q) begin
                    bus_start_d      = 1'b1;
                    bus_address_d    = cur_bus_q;
                    bus_burst_size_d = burst_beats[7:0] - 8'd1;
                    bus_read_d       = dir_rd_q;
                    beats_d          = burst_beats[8:0];
                    state_d          = dir_rd_q ? RD_DATA : WR_FETCH;
                end
            end
            RD_DATA: begin
                if (rd_beat) begin
                    cur_buf_d   = cur_buf_q + 9'd1;
                    cur_bus_d   = cur_bus_q + 32'd4;
                    remaining_d = remaining_q - 10'd1;
                    beats_d     = beats_q - 9'd1;
                end
                if (ci.busEndTransaction) begin
                    bus_request_d = 1'b0;
                    if (remaining_d != 10'd0) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            WR_FETCH: state_d = WR_DATA;
            WR_DATA: begin
                if (!ci.busBusy) begin
                    cur_buf_d    = cur_buf_q + 9'd1;
                    cur_bus_d    = cur_bus_q + 32'd4;
                    remaining_d  = remaining_q - 10'd1;
                    beats_d      = beats_q - 9'd1;
                    wdata_hold_d = 1'b0;
                    if (beats_q != 9'd1) begin
                        state_d = WR_FETCH;
                    end else begin
                        bus_request_d = 1'b0;
                        if (remaining_q != 10'd1) begin
                            state_d = REQ;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end else if (!wdata_hold_q) begin
                    // SSRAM output moves on once the address is released; keep the beat stable
                    wdata_d      = ci.bufDataIn;
                    wdata_hold_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (ci.busError && state_q != IDLE) begin
            error_d          = 1'b1;
            busy_d           = 1'b0;
            state_d          = IDLE;
            bus_request_d    = 1'b0;
            bus_start_d      = 1'b0;
            bus_address_d    = 32'd0;
            bus_burst_size_d = 8'd0;
            bus_read_d       = 1'b0;
            wdata_hold_d     = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            bus_addr_q       <= 32'd0;
            buf_addr_q       <= 9'd0;
            block_size_q     <= 10'd0;
            burst_size_q     <= 8'd0;
            busy_q           <= 1'b0;
            error_q          <= 1'b0;
            dir_rd_q         <= 1'b0;
            cur_bus_q        <= 32'd0;
            cur_buf_q        <= 9'd0;
            remaining_q      <= 10'd0;
            beats_q          <= 9'd0;
            bus_request_q    <= 1'b0;
            bus_start_q      <= 1'b0;
            bus_address_q    <= 32'd0;
            bus_burst_size_q <= 8'd0;
            bus_read_q       <= 1'b0;
            wdata_q          <= 32'd0;
            wdata_hold_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            bus_addr_q       <= bus_addr_d;
            buf_addr_q       <= buf_addr_d;
            block_size_q     <= block_size_d;
            burst_size_q     <= burst_size_d;
            busy_q           <= busy_d;
            error_q          <= error_d;
            dir_rd_q         <= dir_rd_d;
            cur_bus_q        <= cur_bus_d;
            cur_buf_q        <= cur_buf_d;
            remaining_q      <= remaining_d;
            beats_q          <= beats_d;
            bus_request_q    <= bus_request_d;
            bus_start_q      <= bus_start_d;
            bus_address_q    <= bus_address_d;
            bus_burst_size_q <= bus_burst_size_d;
            bus_read_q       <= bus_read_d;
            wdata_q          <= wdata_d;
            wdata_hold_q     <= wdata_hold_d;
        end
    end

    assign ci.done            = ci_active;
    assign ci.result          = rd_data;
    assign ci.bufWriteEnable  = rd_beat;
    assign ci.bufAddress      = (state_q == RD_DATA || state_q == WR_FETCH) ? cur_buf_q : 9'd0;
    assign ci.bufDataOut      = rd_beat ? ci.busDataIn : 32'd0;
    assign ci.busRequest      = bus_request_q;
    assign ci.busStart        = bus_start_q;
    assign ci.busAddress      = bus_address_q;
    assign ci.busBurstSize    = bus_burst_size_q;
    assign ci.busRead         = bus_read_q;
    assign ci.busDataOutValid = (state_q == WR_DATA);
    assign ci.busDataOut      = (state_q != WR_DATA) ? 32'd0 : (wdata_hold_q ? wdata_q : ci.bufDataIn);
endmodule

// File: tb/tb_dma_ci_controller.sv
// Directed bench for dma_ci_controller: CI register access, read/write DMA, wrap, errors and reset.
module tb_dma_ci_controller;
    logic clock = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total = 0;

    dma_ci_if bi();
    dma_ci_controller #(.customId(8'h00)) dut (.clock(clock), .reset(reset), .ci(bi));

    always #5 clock = ~clock;

    logic [31:0] mem [512];
    logic        pl_we = 1'b0;
    logic [8:0]  pl_addr = 9'd0;
    logic [31:0] pl_data = 32'd0;

    always @(posedge clock) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bi.bufWriteEnable) mem[bi.bufAddress] <= bi.bufDataOut;
        bi.bufDataIn <= mem[bi.bufAddress];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ci_wr(input logic [2:0] sel, input logic [31:0] d);
        bi.start = 1'b1; bi.ciN = 8'h00; bi.valueA = {19'd0, sel, 1'b1, 9'd0}; bi.valueB = d;
        #1;
        chk("ci_wr_done", 32'(bi.done), 1);
        tick();
        bi.start = 1'b0; bi.valueA = 32'd0; bi.valueB = 32'd0;
    endtask

    task automatic ci_rd(input logic [2:0] sel, output logic [31:0] d);
        bi.start = 1'b1; bi.ciN = 8'h00; bi.valueA = {19'd0, sel, 1'b0, 9'd0}; bi.valueB = 32'd0;
        #1;
        d = bi.result;
        tick();
        bi.start = 1'b0; bi.valueA = 32'd0;
    endtask

    task automatic grant(input logic [31:0] exp_addr, input logic [7:0] exp_bsz, input logic exp_rd);
        int k;
        k = 0;
        while (bi.busRequest !== 1'b1 && k < 20) begin tick(); k++; end
        chk("bus_request", 32'(bi.busRequest), 1);
        bi.busGrant = 1'b1;
        tick();
        bi.busGrant = 1'b0;
        chk("bus_start", 32'(bi.busStart), 1);
        chk("bus_address", bi.busAddress, exp_addr);
        chk("bus_burst_size", 32'(bi.busBurstSize), 32'(exp_bsz));
        chk("bus_read", 32'(bi.busRead), 32'(exp_rd));
    endtask

    task automatic rd_burst(input logic [31:0] exp_addr, input logic [7:0] exp_bsz,
                            input logic [8:0] exp_buf, input logic [31:0] d0, input int n);
        logic [8:0] ba;
        grant(exp_addr, exp_bsz, 1'b1);
        for (int i = 0; i < n; i++) begin
            ba = exp_buf + 9'(i);
            bi.busDataInValid = 1'b1; bi.busDataIn = d0 + 32'(i);
            #1;
            chk("buf_we", 32'(bi.bufWriteEnable), 1);
            chk("buf_addr", 32'(bi.bufAddress), 32'(ba));
            chk("buf_wdata", bi.bufDataOut, d0 + 32'(i));
            tick();
        end
        bi.busDataInValid = 1'b0; bi.busDataIn = 32'd0;
        bi.busEndTransaction = 1'b1;
        tick();
        bi.busEndTransaction = 1'b0;
    endtask

    task automatic wr_burst(input logic [31:0] exp_addr, input logic [7:0] exp_bsz, input logic [8:0] exp_buf,
                            input logic [31:0] d0, input int n, input int stall_beat, input int stall_len);
        grant(exp_addr, exp_bsz, 1'b0);
        #1;
        chk("fetch_addr", 32'(bi.bufAddress), 32'(exp_buf));
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == stall_beat) begin
                bi.busBusy = 1'b1;
                for (int s = 0; s < stall_len; s++) begin
                    #1;
                    chk("stall_valid", 32'(bi.busDataOutValid), 1);
                    chk("stall_data", bi.busDataOut, d0 + 32'(i));
                    tick();
                end
                bi.busBusy = 1'b0;
            end
            #1;
            chk("wr_valid", 32'(bi.busDataOutValid), 1);
            chk("wr_data", bi.busDataOut, d0 + 32'(i));
            tick();
        end
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b1;
        bi.start = 1'b0; bi.ciN = 8'h00; bi.valueA = 32'd0; bi.valueB = 32'd0;
        bi.busGrant = 1'b0; bi.busDataIn = 32'd0; bi.busDataInValid = 1'b0;
        bi.busBusy = 1'b0; bi.busEndTransaction = 1'b0; bi.busError = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busRequest", 32'(bi.busRequest), 0);
        chk("rst_busStart", 32'(bi.busStart), 0);
        chk("rst_bufWe", 32'(bi.bufWriteEnable), 0);
        chk("rst_wrValid", 32'(bi.busDataOutValid), 0);
        chk("rst_done", 32'(bi.done), 0);
        chk("rst_result", bi.result, 0);
        reset = 1'b0;
        tick();
        ci_rd(3'd5, v); chk("rst_status", v, 0);
        ci_rd(3'd1, v); chk("rst_busAddr", v, 0);

        // register access and saturation
        ci_wr(3'd1, 32'h0000_1003); ci_rd(3'd1, v); chk("busAddr_mask", v, 32'h1000);
        ci_wr(3'd3, 32'd600);       ci_rd(3'd3, v); chk("blockSize_sat", v, 32'd512);
        ci_wr(3'd2, 32'd0); ci_wr(3'd3, 32'd8); ci_wr(3'd4, 32'd3);
        ci_rd(3'd4, v); chk("burstSize_rd", v, 32'd3);

        // read DMA, two full bursts, with busy protection while requesting
        ci_wr(3'd5, 32'd1);
        chk("req_after_start", 32'(bi.busRequest), 1);
        ci_wr(3'd1, 32'hDEAD_0000);
        ci_wr(3'd5, 32'd2);
        ci_rd(3'd1, v); chk("busy_wr_ignored", v, 32'h1000);
        ci_rd(3'd5, v); chk("status_busy", v, 32'd1);
        rd_burst(32'h1000, 8'd3, 9'd0, 32'h100, 4);
        rd_burst(32'h1010, 8'd3, 9'd4, 32'h104, 4);
        chk("rd_done_req", 32'(bi.busRequest), 0);
        ci_rd(3'd5, v); chk("rd_done_status", v, 0);
        for (int i = 0; i < 8; i++) chk("rd_mem", mem[i], 32'h100 + 32'(i));

        // uneven tail
        ci_wr(3'd1, 32'h2000); ci_wr(3'd2, 32'd20); ci_wr(3'd3, 32'd10); ci_wr(3'd5, 32'd1);
        rd_burst(32'h2000, 8'd3, 9'd20, 32'h200, 4);
        rd_burst(32'h2010, 8'd3, 9'd24, 32'h204, 4);
        rd_burst(32'h2020, 8'd1, 9'd28, 32'h208, 2);
        ci_rd(3'd5, v); chk("tail_status", v, 0);
        chk("tail_mem29", mem[29], 32'h209);

        // write DMA with a 3-cycle stall on beat 2
        for (int i = 0; i < 4; i++) begin
            pl_we = 1'b1; pl_addr = 9'd5 + 9'(i); pl_data = 32'hA0 + 32'(i);
            tick();
        end
        pl_we = 1'b0;
        ci_wr(3'd1, 32'h3000); ci_wr(3'd2, 32'd5); ci_wr(3'd3, 32'd4); ci_wr(3'd5, 32'd2);
        wr_burst(32'h3000, 8'd3, 9'd5, 32'hA0, 4, 1, 3);
        chk("wr_done_req", 32'(bi.busRequest), 0);
        ci_rd(3'd5, v); chk("wr_done_status", v, 0);

        // buffer address wrap
        ci_wr(3'd1, 32'h6000); ci_wr(3'd2, 32'd510); ci_wr(3'd3, 32'd4); ci_wr(3'd5, 32'd1);
        rd_burst(32'h6000, 8'd3, 9'd510, 32'h500, 4);
        chk("wrap_mem510", mem[510], 32'h500);
        chk("wrap_mem511", mem[511], 32'h501);
        chk("wrap_mem0", mem[0], 32'h502);
        chk("wrap_mem1", mem[1], 32'h503);

        // bus error mid-burst
        ci_wr(3'd1, 32'h4000); ci_wr(3'd2, 32'd100); ci_wr(3'd3, 32'd8); ci_wr(3'd5, 32'd1);
        grant(32'h4000, 8'd3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            bi.busDataInValid = 1'b1; bi.busDataIn = 32'h700 + 32'(i);
            tick();
        end
        bi.busDataInValid = 1'b0;
        bi.busError = 1'b1;
        tick();
        bi.busError = 1'b0;
        chk("err_req_drop", 32'(bi.busRequest), 0);
        ci_rd(3'd5, v); chk("err_status", v, 32'd2);
        bi.busDataInValid = 1'b1; bi.busDataIn = 32'hBAD;
        #1;
        chk("idle_beat_ignored", 32'(bi.bufWriteEnable), 0);
        bi.busDataInValid = 1'b0;
        tick();

        // zero-length start clears error and stays idle
        ci_wr(3'd3, 32'd0); ci_wr(3'd5, 32'd1);
        ci_rd(3'd5, v); chk("zero_len_status", v, 0);
        chk("zero_len_req", 32'(bi.busRequest), 0);

        // unmapped select, foreign opcode
        ci_rd(3'd6, v); chk("sel6_read", v, 0);
        ci_wr(3'd0, 32'h1234);
        ci_rd(3'd2, v); chk("bufAddr_rd", v, 32'd100);
        bi.start = 1'b1; bi.ciN = 8'h01; bi.valueA = {19'd0, 3'd2, 1'b0, 9'd0};
        #1;
        chk("foreign_done", 32'(bi.done), 0);
        chk("foreign_result", bi.result, 0);
        tick();
        bi.start = 1'b0; bi.ciN = 8'h00; bi.valueA = 32'd0;

        // async reset in the middle of a write burst
        ci_wr(3'd1, 32'h5000); ci_wr(3'd2, 32'd5); ci_wr(3'd3, 32'd4); ci_wr(3'd5, 32'd2);
        grant(32'h5000, 8'd3, 1'b0);
        tick();
        #1;
        chk("pre_reset_valid", 32'(bi.busDataOutValid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_wrValid", 32'(bi.busDataOutValid), 0);
        chk("arst_busRequest", 32'(bi.busRequest), 0);
        chk("arst_busDataOut", bi.busDataOut, 0);
        chk("arst_bufAddress", 32'(bi.bufAddress), 0);
        tick();
        reset = 1'b0;
        tick();
        ci_rd(3'd5, v); chk("post_reset_status", v, 0);
        ci_rd(3'd1, v); chk("post_reset_busAddr", v, 0);
        chk("post_reset_req", 32'(bi.busRequest), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/dma_ci_controller.md
# dma_ci_controller

- Custom-instruction-configured DMA controller.
- Moves word blocks between the system bus and the 512-entry local CI buffer SSRAM.
- Uses the SSRAM's second port (port B); the CPU-facing CI path keeps port A.
- CPU programs addresses and sizes, then starts a transfer with CI writes. The block splits the transfer into bus bursts, arbitrates for the bus, and sequences port B.

## Interface
Parameters:
- customId, 8'h00, CI opcode this block answers to

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  CI start strobe
- ciN  in  8  CI opcode, decoded against customId
- valueA  in  32  CI operand A: [12:10] register select, [9] write(1)/read(0)
- valueB  in  32  CI write data
- done  out  1  CI completion
- result  out  32  CI read data, 0 when done=0
- bufAddress  out  9  SSRAM port B address
- bufWriteEnable  out  1  SSRAM port B write strobe
- bufDataOut  out  32  SSRAM port B write data
- bufDataIn  in  32  SSRAM port B read data, valid 1 cycle after address
- busRequest  out  1  bus arbitration request
- busGrant  in  1  bus granted
- busAddress  out  32  burst start address, valid while busStart=1, else 0
- busBurstSize  out  8  beats-1, valid while busStart=1, else 0
- busStart  out  1  one-cycle transaction start
- busRead  out  1  qualifies busStart as a read
- busDataIn  in  32  read beat data
- busDataInValid  in  1  read beat valid
- busDataOut  out  32  write beat data
- busDataOutValid  out  1  write beat valid
- busBusy  in  1  slave stall; a write beat is accepted when busDataOutValid & !busBusy
- busEndTransaction  in  1  slave ends the burst
- busError  in  1  bus error; aborts the transfer

## Operation
CI is active when start & ciN==customId. done=1 in that same cycle for every access (single-cycle CI).

Registers (select = valueA[12:10]):
- 1 busAddr: 32 bits; bits [1:0] are forced to 0.
- 2 bufAddr: 9 bits.
- 3 blockSize: 10 bits, in words; values above 512 saturate to 512.
- 4 burstSize: 8 bits, beats-1.
- 5 control.
  - Write valueB[1:0]: 01 = bus->buffer, 10 = buffer->bus; other values are ignored.
  - Read returns {30'b0, error, busy}.

Register access rules:
- Reads of 1-4 return the register value zero-extended.
- Select 0, 6 or 7: reads return 0 and writes are ignored.
- Writes to 1-5 while busy=1 are ignored (done still 1).
- A start with blockSize==0 leaves busy=0.
- Any accepted start clears error.

FSM states: IDLE, REQ, RD_DATA, WR_FETCH, WR_DATA.
- IDLE: on accepted start with blockSize>0:
  - latch working copies: curBus=busAddr, curBuf=bufAddr, remaining=blockSize;
  - set busy=1; go to REQ.
- REQ:
  - Hold busRequest=1 until busGrant.
  - On grant, for one cycle:
    - assert busStart;
    - drive busAddress=curBus;
    - drive busBurstSize=min(burstSize+1, remaining)-1;
    - drive busRead=1 for a read.
  - Latch beats = busBurstSize+1.
  - Next state is RD_DATA (read) or WR_FETCH (write).
  - busRequest stays 1 from REQ until leaving the burst.
- RD_DATA: each busDataInValid writes the beat to the buffer in the same cycle:
  - bufWriteEnable=1, bufAddress=curBuf, bufDataOut=busDataIn;
  - then curBuf+1 (mod 512), remaining-1, beats-1.
- RD_DATA exit, on busEndTransaction:
  - curBus += 4*(words moved);
  - go to REQ if remaining>0, else IDLE.
- WR_FETCH: drive bufAddress=curBuf for one cycle, then go to WR_DATA.
- WR_DATA: busDataOutValid=1 with busDataOut=bufDataIn, registered and held stable while busBusy.
  - On acceptance: curBuf+1, remaining-1, beats-1.
  - If beats>0 after acceptance: go to WR_FETCH.
  - Otherwise: release the bus, then go to REQ if remaining>0, else IDLE.
- busError in any non-IDLE state:
  - error=1, busy=0;
  - all bus outputs drop next cycle; go to IDLE.
- Read-beat writes outside RD_DATA are ignored.

Address arithmetic:
- Buffer address wraps 511->0.
- Bus address is 32-bit modulo.

## Timing
Reset values: every output 0; all registers 0; busy=0, error=0; FSM=IDLE.
- Reset mid-transfer aborts immediately. Partially written buffer words persist.
- CI: done and result are combinational in the start cycle. busy reads 1 from the cycle after the starting write.
- Request: busRequest rises the cycle after the start.
- Grant: busStart is asserted in the cycle after busGrant is first seen with busRequest=1.
- Write beat rate: at most one beat per 2 cycles (fetch + data).
- Completion: busy falls the cycle after the final busEndTransaction (read) or final beat acceptance (write).

## Test plan
- Read DMA: busAddr=0x1000, bufAddr=0, blockSize=8, burstSize=3, start 01 -> two bursts at 0x1000 and 0x1010, each busBurstSize=3. Buffer words 0-7 equal the bus data; busy falls after the 2nd end.
- Uneven tail: blockSize=10, burstSize=3 -> bursts of 4, 4, 2 (busBurstSize 3, 3, 1) at 0x..00, 0x..10, 0x..20.
- Write DMA with stalls: preload buffer 5-8 with 0xA0-0xA3; bufAddr=5, blockSize=4, start 10, busBusy=1 for 3 cycles on beat 2 -> beats out in order. busDataOut stays 0xA1 throughout the stall.
- Wrap and errors: bufAddr=510, blockSize=4 read -> writes to 510, 511, 0, 1. Separately, busError mid-burst -> status reads 2'b10 and busRequest=0 next cycle.
- Busy protection: register write and second start while busy -> ignored, done=1. blockSize=0 start -> status 0, no busRequest. Select 6 read -> result 0.
- Async reset asserted mid-write burst -> all outputs 0 immediately; status reads 0 after release.
